// File: rtl/writeback_unit.sv
// ----------------------------------------------------------------------------
// writeback_unit
//
// Purpose:
//   Writeback stage in front of the register file. It merges the single-cycle
//   ALU result (never stalled, highest priority) and the load result path
//   (buffered in a small in-order FIFO) onto the file's single write port.
//   It also keeps write-after-write order between the two paths and exports a
//   per-register pending-load mask for load-use hazard detection in decode.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   alu_valid/alu_rd/alu_data
//                           ALU result (alu_rd==0 means no result)
//   mem_valid/mem_ready/mem_rd/mem_data
//                           load result handshake into the FIFO
//   reg_write/write_reg/write_data
//                           registered register-file write port
//   pending                 bit r set while a live queued load targets r
//   fifo_count              occupied FIFO slots, killed entries included
//
// Handshake: a load transfers on a rising edge where mem_valid && mem_ready
// are both high. mem_ready depends only on the registered occupancy, so it
// never combinationally depends on mem_valid or on a pop in the same cycle.
// ----------------------------------------------------------------------------
module writeback_unit #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [NREG-1:0]   pending,
  output logic [CNT_W-1:0]  fifo_count
);

  // FIFO storage: live bits are reset state, payload is not.
  logic [DEPTH-1:0]  r_live;
  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  logic              w_alu_wr;
  logic              w_accept;
  logic              w_enq;
  logic              w_enq_live;
  logic              w_deq;
  logic [NREG-1:0]   w_pending;

  // Register 0 is hard-wired, so an ALU result to it is no result at all.
  assign w_alu_wr   = alu_valid && (alu_rd != '0);
  assign mem_ready  = (r_count < CNT_W'(DEPTH));
  assign w_accept   = mem_valid && mem_ready;
  // A load to register 0 completes the handshake but occupies no slot.
  assign w_enq      = w_accept && (mem_rd != '0);
  // The ALU write is program-later than a load accepted in the same cycle,
  // so such a load is enqueued already dead.
  assign w_enq_live = !(w_alu_wr && (mem_rd == alu_rd));
  // The FIFO only gets the port when the ALU is not using it.
  assign w_deq      = !w_alu_wr && (r_count != '0);

  // Live bits are cleared on pop, so live alone implies an occupied slot.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_pending[r_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      // WAW kill: an ALU write supersedes every queued load to the same rd.
      if (w_alu_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd[i] == alu_rd) r_live[i] <= 1'b0;
        end
      end

      if (w_deq) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + PTR_W'(1);
      end

      // The write slot is free whenever w_enq is high, so this assignment
      // (placed last) correctly overrides the kill loop for that slot.
      if (w_enq) begin
        r_live[r_wptr] <= w_enq_live;
        r_wptr         <= r_wptr + PTR_W'(1);
      end

      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

      // Write port arbitration: ALU first, then FIFO head, else idle.
      // A killed head consumes its slot without writing; index and data
      // hold their last values whenever no write is issued.
      if (w_alu_wr) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= alu_rd;
        r_write_data <= alu_data;
      end else if (w_deq) begin
        r_reg_write <= r_live[r_rptr];
        if (r_live[r_rptr]) begin
          r_write_reg  <= r_rd[r_rptr];
          r_write_data <= r_data[r_rptr];
        end
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: it is only read behind a live bit.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= mem_rd;
      r_data[r_wptr] <= mem_data;
    end
  end

  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign pending    = w_pending;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_writeback_unit.sv
// ----------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed and randomized steps against a queue-based reference model of the
// writeback stage. Each step drives one cycle of inputs, checks the
// pre-edge outputs (mem_ready, fifo_count, pending), then checks the
// registered write port after the edge.
// ----------------------------------------------------------------------------
module tb_writeback_unit;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int NREG   = 2 ** ADDR_W;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  fifo_count;

  writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit                live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t                      mq[$];
  logic [ADDR_W+DATA_W-1:0]  exp_q[$];   // expected register-file writes, in order
  logic                      e_we;
  logic [ADDR_W-1:0]         e_wr;
  logic [DATA_W-1:0]         e_wd;
  bit                        acc;        // last step's load was accepted

  int n_cmp;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    e_we = 1'b0;
    e_wr = '0;
    e_wd = '0;
  endtask

  // ---------------- driver: one cycle per call, entered at posedge+1 ----------------
  task automatic step(input bit av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                      input bit mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
    bit   ready;
    bit   alu_wr;
    ent_t h;
    logic [ADDR_W+DATA_W-1:0] want;

    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    #1;
    ready = (mq.size() < DEPTH);
    chk("mem_ready", mem_ready, ready);
    chk("fifo_count", fifo_count, mq.size());
    chk("pending", pending, model_pending());

    alu_wr = av && (ard != 0);
    acc    = mv && ready;
    if (alu_wr) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      e_we = 1'b1;
      e_wr = ard;
      e_wd = ad;
      exp_q.push_back({ard, ad});
    end else if (mq.size() > 0) begin
      h    = mq.pop_front();
      e_we = h.live;
      if (h.live) begin
        e_wr = h.rd;
        e_wd = h.data;
        exp_q.push_back({h.rd, h.data});
      end
    end else begin
      e_we = 1'b0;
    end
    if (acc && mrd != 0) mq.push_back('{live: !(alu_wr && mrd == ard), rd: mrd, data: md});

    @(posedge clk);
    #1;
    chk("reg_write", reg_write, e_we);
    chk("write_reg", write_reg, e_wr);
    chk("write_data", write_data, e_wd);
    if (reg_write === 1'b1) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("sb_write", {write_reg, write_data}, want);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int guard;
    n_cmp  = 0;
    n_fail = 0;
    acc    = 0;
    model_clear();

    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;

    // Reset state
    #12;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mem_ready", mem_ready, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single load in an idle cycle: pending[3] for one cycle, then the write.
    step(0, 0, 0, 1, 4'd3, 16'h1234);
    idle();
    idle();

    // Fill: ALU to R9 held for 6 cycles while loads R1..R5 are offered.
    k = 1;
    guard = 0;
    while (k <= 5 && guard < 30) begin
      step(guard < 6, 4'd9, DATA_W'(16'h0900 + guard), 1, ADDR_W'(k), DATA_W'(16'h1000 + k));
      if (acc) k++;
      guard++;
    end
    chk("fill_all_accepted", k, 6);
    repeat (3) idle();

    // WAW kill of a queued load to R6.
    step(1, 4'd9, 16'h0999, 1, 4'd6, 16'hAAAA);
    step(1, 4'd6, 16'h5555, 0, 0, 0);
    repeat (2) idle();

    // Same-cycle ALU and load to R7: load enters dead.
    step(1, 4'd7, 16'h7777, 1, 4'd7, 16'h8888);
    repeat (2) idle();

    // R0 destinations on both paths: no writes, no occupancy.
    step(1, 4'd0, 16'hDEAD, 1, 4'd0, 16'hBEEF);
    step(0, 4'd0, 16'h0000, 1, 4'd0, 16'hCAFE);
    idle();

    // Reset mid-drain: 4 queued, pop one (reg_write=1, 3 left), then reset.
    for (int i = 1; i <= 4; i++) step(1, 4'd10, DATA_W'(16'h0A00 + i), 1, ADDR_W'(i), DATA_W'(16'h2000 + i));
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_reg_write", reg_write, 0);
    chk("mid_rst_write_reg", write_reg, 0);
    chk("mid_rst_write_data", write_data, 0);
    chk("mid_rst_fifo_count", fifo_count, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_mem_ready", mem_ready, 1);
    model_clear();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) idle();

    // Randomized traffic; small register range to force collisions.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           $urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
    end
    repeat (DEPTH + 2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
